// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - FunSel encodings shared by the register file and its ALU cells
package reg_pkg;

  typedef logic [2:0] funsel_t;

  localparam funsel_t FS_CLR  = 3'b000;
  localparam funsel_t FS_LOAD = 3'b001;
  localparam funsel_t FS_DEC  = 3'b010;
  localparam funsel_t FS_INC  = 3'b011;
  localparam funsel_t FS_SHL  = 3'b100;
  localparam funsel_t FS_SHR  = 3'b101;
  localparam funsel_t FS_ROL  = 3'b110;
  localparam funsel_t FS_ROR  = 3'b111;

endpackage

// File: rtl/multi_function_reg_file_if.sv
// rtl/multi_function_reg_file_if.sv - operation, load and read-port signals of the register file
interface multi_function_reg_file_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = $clog2(DEPTH)
);
  import reg_pkg::*;

  logic [DEPTH-1:0] E;
  funsel_t          FunSel;
  logic [W-1:0]     I;
  logic [SELW-1:0]  OutASel;
  logic [SELW-1:0]  OutBSel;
  logic [W-1:0]     OutA;
  logic [W-1:0]     OutB;
  logic             Z;
  logic             C;

  modport master (
    output E, FunSel, I, OutASel, OutBSel,
    input  OutA, OutB, Z, C
  );

  modport slave (
    input  E, FunSel, I, OutASel, OutBSel,
    output OutA, OutB, Z, C
  );
endinterface

// File: rtl/reg_alu_cell.sv
// rtl/reg_alu_cell.sv - next value and carry for one register; REG_SAT_EN makes inc/dec saturate
module reg_alu_cell
  import reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q,
  input  funsel_t      funsel,
  input  logic [W-1:0] i,
  output logic [W-1:0] nxt,
  output logic         carry
);

`ifndef REG_SAT_EN
  logic [W:0] sum;
  logic [W:0] diff;

  // The extra top bit is the carry out of increment and the borrow of decrement.
  assign sum  = {1'b0, q} + {{W{1'b0}}, 1'b1};
  assign diff = {1'b0, q} - {{W{1'b0}}, 1'b1};
`endif

  always_comb begin
    nxt   = q;
    carry = 1'b0;
    case (funsel)
      FS_CLR:  nxt = '0;
      FS_LOAD: nxt = i;
`ifdef REG_SAT_EN
      FS_DEC: begin
        if (q == '0) begin
          nxt   = '0;
          carry = 1'b1;
        end else begin
          nxt = q - {{(W-1){1'b0}}, 1'b1};
        end
      end
      FS_INC: begin
        if (&q) begin
          nxt   = q;
          carry = 1'b1;
        end else begin
          nxt = q + {{(W-1){1'b0}}, 1'b1};
        end
      end
`else
      FS_DEC: begin
        nxt   = diff[W-1:0];
        carry = diff[W];
      end
      FS_INC: begin
        nxt   = sum[W-1:0];
        carry = sum[W];
      end
`endif
      FS_SHL: begin
        nxt   = {q[W-2:0], 1'b0};
        carry = q[W-1];
      end
      FS_SHR: begin
        nxt   = {1'b0, q[W-1:1]};
        carry = q[0];
      end
      FS_ROL: begin
        nxt   = {q[W-2:0], q[W-1]};
        carry = q[W-1];
      end
      FS_ROR: begin
        nxt   = {q[0], q[W-1:1]};
        carry = q[0];
      end
      default: begin
        nxt   = q;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_function_reg_file.sv
// rtl/multi_function_reg_file.sv - register file applying one FunSel op to every enabled register; REG_SAT_EN selects saturating inc/dec
module multi_function_reg_file
  import reg_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = $clog2(DEPTH)
) (
  input logic                       Clock,
  input logic                       Reset,
  multi_function_reg_file_if.slave  bus
);

  logic [W-1:0] regs [DEPTH];
  logic [W-1:0] nxt  [DEPTH];
  logic         cy   [DEPTH];
  logic [W-1:0] flag_val;
  logic         flag_cy;
  logic [W-1:0] outa;
  logic [W-1:0] outb;
  logic         z_q;
  logic         c_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    reg_alu_cell #(.W(W)) u_cell (
      .q      (regs[k]),
      .funsel (bus.FunSel),
      .i      (bus.I),
      .nxt    (nxt[k]),
      .carry  (cy[k])
    );
  end

  // Scanning downward lets the lowest enabled index overwrite the others.
  always_comb begin
    flag_val = '0;
    flag_cy  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (bus.E[k]) begin
        flag_val = nxt[k];
        flag_cy  = cy[k];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.E[k]) begin
          regs[k] <= nxt[k];
        end
      end
      if (|bus.E) begin
        z_q <= (flag_val == '0);
        c_q <= flag_cy;
      end
    end
  end

  always_comb begin
    outa = '0;
    outb = '0;
    if (int'(bus.OutASel) < DEPTH) begin
      outa = regs[bus.OutASel];
    end
    if (int'(bus.OutBSel) < DEPTH) begin
      outb = regs[bus.OutBSel];
    end
  end

  assign bus.OutA = outa;
  assign bus.OutB = outb;
  assign bus.Z    = z_q;
  assign bus.C    = c_q;

endmodule
